// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD issue controller: opcodes, FSM states,
// decoded-instruction and ALU-select types, default lane geometry.
package simd_pkg;

    localparam int unsigned LANES_DEF = 4;
    localparam int unsigned DW_DEF    = 16;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_BITREV = 4'd3;
    localparam logic [3:0] OP_MUL    = 4'd4;
    localparam logic [3:0] OP_LDI    = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_e;

    typedef struct packed {
        logic add;
        logic sub;
        logic bitrev;
        logic mul;
    } alu_sel_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
    } instr_t;

    // imm overlaps the low bits of rs2; both views are kept
    function automatic instr_t split_instr(input logic [31:0] w);
        instr_t f;
        f.op  = w[31:28];
        f.rd  = w[27:23];
        f.rs1 = w[22:18];
        f.rs2 = w[17:13];
        f.imm = w[15:0];
        return f;
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_BITREV) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/simd_decode.sv
// Combinational opcode decode: one-hot ALU select, register write flag,
// ALU-class flag and illegal-opcode flag.
module simd_decode
    import simd_pkg::*;
(
    input  logic [3:0] op,
    output alu_sel_t   alu_sel,
    output logic       is_alu,
    output logic       wr_en,
    output logic       illegal
);

    always_comb begin
        alu_sel = '0;
        is_alu  = 1'b0;
        wr_en   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD: begin
                alu_sel.add = 1'b1;
                is_alu      = 1'b1;
                wr_en       = 1'b1;
            end
            OP_SUB: begin
                alu_sel.sub = 1'b1;
                is_alu      = 1'b1;
                wr_en       = 1'b1;
            end
            OP_BITREV: begin
                alu_sel.bitrev = 1'b1;
                is_alu         = 1'b1;
                wr_en          = 1'b1;
            end
            OP_MUL: begin
                alu_sel.mul = 1'b1;
                is_alu      = 1'b1;
                wr_en       = 1'b1;
            end
            OP_LDI:  wr_en   = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/simd_issue_ctrl.sv
// Lockstep SIMD issue controller: accepts one instruction at a time and
// sequences register read, ALU execute and writeback across all lanes.
module simd_issue_ctrl
    import simd_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic                rs1_rd_en,
    output logic                rs2_rd_en,
    output logic                rd_wr_en,
    output logic                Radd_en,
    output logic                Rsub_en,
    output logic                bitrev_en,
    output logic                mul_en,
    output logic [LANES*DW-1:0] wr_data,
    input  logic [LANES*DW-1:0] alu_result,
    output logic                done,
    output logic                illegal_op
);

    state_e                state_q;
    state_e                state_d;
    instr_t                ir_q;
    logic [LANES*DW-1:0]   res_q;
    logic                  accept;

    alu_sel_t              dec_sel;
    logic                  dec_is_alu;
    logic                  dec_wr_en;
    logic                  dec_illegal;

    simd_decode u_decode (
        .op      (ir_q.op),
        .alu_sel (dec_sel),
        .is_alu  (dec_is_alu),
        .wr_en   (dec_wr_en),
        .illegal (dec_illegal)
    );

    // ready is gated by rst_n so it drops the instant reset asserts
    assign instr_ready = rst_n && (state_q == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q <= split_instr(instr);
            end
            if (state_q == S_EXEC) begin
                res_q <= alu_result;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_alu_op(instr[31:28]) ? S_READ : S_WB;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rs1        = '0;
        rs2        = '0;
        rd         = '0;
        rs1_rd_en  = 1'b0;
        rs2_rd_en  = 1'b0;
        rd_wr_en   = 1'b0;
        Radd_en    = 1'b0;
        Rsub_en    = 1'b0;
        bitrev_en  = 1'b0;
        mul_en     = 1'b0;
        wr_data    = '0;
        done       = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_READ, S_EXEC: begin
                rs1       = ir_q.rs1;
                rs2       = ir_q.rs2;
                rs1_rd_en = 1'b1;
                rs2_rd_en = 1'b1;
                Radd_en   = dec_sel.add;
                Rsub_en   = dec_sel.sub;
                bitrev_en = dec_sel.bitrev;
                mul_en    = dec_sel.mul;
            end
            S_WB: begin
                rd         = ir_q.rd;
                done       = 1'b1;
                rd_wr_en   = dec_wr_en;
                illegal_op = dec_illegal;
                if (dec_wr_en) begin
                    if (dec_is_alu) begin
                        wr_data = res_q;
                    end else begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            wr_data[i*DW +: DW] = DW'(ir_q.imm);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Self-checking bench for simd_issue_ctrl: transaction-level model driven by
// directed scenarios and randomized traffic, compared every cycle.
module tb_simd_issue_ctrl;

    localparam int LANES = 4;
    localparam int DW    = 16;

    logic                clk;
    logic                rst_n;
    logic [31:0]         instr;
    logic                instr_valid;
    logic                instr_ready;
    logic [4:0]          rs1, rs2, rd;
    logic                rs1_rd_en, rs2_rd_en, rd_wr_en;
    logic                Radd_en, Rsub_en, bitrev_en, mul_en;
    logic [LANES*DW-1:0] wr_data;
    logic [LANES*DW-1:0] alu_result;
    logic                done, illegal_op;

    simd_issue_ctrl #(.LANES(LANES), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .rs1_rd_en   (rs1_rd_en),
        .rs2_rd_en   (rs2_rd_en),
        .rd_wr_en    (rd_wr_en),
        .Radd_en     (Radd_en),
        .Rsub_en     (Rsub_en),
        .bitrev_en   (bitrev_en),
        .mul_en      (mul_en),
        .wr_data     (wr_data),
        .alu_result  (alu_result),
        .done        (done),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model: one outstanding instruction, timed by cycle arithmetic
    int          cyc = 0;
    bit          m_have = 1'b0;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [15:0] m_imm;
    int          m_acc = 0;
    logic [63:0] m_cap = '0;
    bit          last_acc = 1'b0;
    bit          chk_en = 1'b0;

    function automatic bit m_is_alu(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_ready, e_r1en, e_r2en, e_we, e_add, e_sub, e_brev, e_mul, e_done, e_ill;
            logic [4:0]  e_rs1, e_rs2, e_rd;
            logic [63:0] e_wd;
            int          ph;
            e_ready = rst_n && !m_have;
            {e_r1en, e_r2en, e_we, e_add, e_sub, e_brev, e_mul, e_done, e_ill} = '0;
            e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_wd = '0;
            ph = cyc - m_acc;
            if (m_have) begin
                if (m_is_alu(m_op)) begin
                    if (ph < 2) begin
                        e_rs1 = m_rs1; e_rs2 = m_rs2; e_r1en = 1'b1; e_r2en = 1'b1;
                        e_add = (m_op == 4'd1); e_sub = (m_op == 4'd2);
                        e_brev = (m_op == 4'd3); e_mul = (m_op == 4'd4);
                    end else begin
                        e_rd = m_rd; e_done = 1'b1; e_we = 1'b1; e_wd = m_cap;
                    end
                end else begin
                    e_rd = m_rd; e_done = 1'b1;
                    if (m_op == 4'd5) begin
                        e_we = 1'b1; e_wd = {4{m_imm}};
                    end else if (m_op != 4'd0) begin
                        e_ill = 1'b1;
                    end
                end
            end
            check("ctrl",
                  64'({instr_ready, rs1, rs2, rd, rs1_rd_en, rs2_rd_en, rd_wr_en,
                       Radd_en, Rsub_en, bitrev_en, mul_en, done, illegal_op}),
                  64'({e_ready, e_rs1, e_rs2, e_rd, e_r1en, e_r2en, e_we,
                       e_add, e_sub, e_brev, e_mul, e_done, e_ill}));
            check("wr_data", wr_data, e_wd);
            check("alu_onehot", 64'($countones({Radd_en, Rsub_en, bitrev_en, mul_en}) <= 1), 64'd1);
        end
    end

    task automatic step();
        bit rdy;
        @(posedge clk);
        rdy = rst_n && !m_have;
        if (m_have && m_is_alu(m_op) && cyc == m_acc + 1) m_cap = alu_result;
        if (m_have && cyc == m_acc + (m_is_alu(m_op) ? 2 : 0)) m_have = 1'b0;
        cyc++;
        last_acc = 1'b0;
        if (rdy && instr_valid) begin
            m_have = 1'b1;
            m_op  = instr[31:28]; m_rd  = instr[27:23];
            m_rs1 = instr[22:18]; m_rs2 = instr[17:13];
            m_imm = instr[15:0];
            m_acc = cyc;
            last_acc = 1'b1;
        end
        #1;
    endtask

    task automatic issue(input logic [31:0] w, input bit hold);
        instr = w;
        instr_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (last_acc) break;
        end
        check("accept_timeout", 64'(last_acc), 64'd1);
        if (!hold) begin
            instr_valid = 1'b0;
            instr = $urandom;
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2, 13'h0};
    endfunction

    initial begin
        int a0, a1, a2;
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; alu_result = '0;
        chk_en = 1'b1;
        #2;
        check("rst_ready", 64'(instr_ready), 64'd0);
        check("rst_outs", 64'({done, rd_wr_en, rs1_rd_en, wr_data != 0}), 64'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 64'(instr_ready), 64'd1);

        // LDI r3, 0x1234
        issue({4'd5, 5'd3, 7'd0, 16'h1234}, 1'b0);
        check("ldi_done", 64'(done), 64'd1);
        check("ldi_rd", 64'(rd), 64'd3);
        check("ldi_we", 64'(rd_wr_en), 64'd1);
        check("ldi_data", wr_data, 64'h1234_1234_1234_1234);
        step();
        check("ldi_ready", 64'({instr_ready, done}), 64'b10);

        // ADD r5 = r1 + r2, lanes return 0x10+i
        alu_result = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        issue(mk(4'd1, 5'd5, 5'd1, 5'd2), 1'b0);
        check("add_read", 64'({Radd_en, rs1, rs2}), 64'({1'b1, 5'd1, 5'd2}));
        step();
        check("add_exec", 64'(Radd_en), 64'd1);
        step();
        check("add_done", 64'({done, rd_wr_en, Radd_en, rd}), 64'({3'b110, 5'd5}));
        check("add_data", wr_data, 64'h0013_0012_0011_0010);
        step();

        // illegal op 9
        issue(mk(4'd9, 5'd4, 5'd0, 5'd0), 1'b0);
        check("ill_pulse", 64'({illegal_op, done, rd_wr_en}), 64'b110);
        step();
        check("ill_clear", 64'({illegal_op, done}), 64'd0);

        // MUL interrupted by reset during EXEC, then ADD
        issue(mk(4'd4, 5'd6, 5'd1, 5'd2), 1'b0);
        step();
        check("mul_exec", 64'(mul_en), 64'd1);
        #2;
        rst_n = 1'b0;
        m_have = 1'b0;
        #1;
        check("mul_rst", 64'({mul_en, done, rd_wr_en, rs1_rd_en, instr_ready}), 64'd0);
        step(); step();
        rst_n = 1'b1;
        alu_result = 64'hAAAA_BBBB_CCCC_DDDD;
        issue(mk(4'd1, 5'd8, 5'd3, 5'd4), 1'b0);
        step(); step();
        check("add2_data", wr_data, 64'hAAAA_BBBB_CCCC_DDDD);
        step();

        // back-to-back with valid held high
        issue(mk(4'd2, 5'd9, 5'd1, 5'd1), 1'b1);  a0 = m_acc;
        issue(mk(4'd3, 5'd10, 5'd2, 5'd0), 1'b1); a1 = m_acc;
        issue(mk(4'd0, 5'd0, 5'd0, 5'd0), 1'b0);  a2 = m_acc;
        check("b2b_gap1", 64'(a1 - a0), 64'd4);
        check("b2b_gap2", 64'(a2 - a1), 64'd4);
        step();

        // SUB r7 = r7 - r2
        alu_result = 64'h0707_0606_0505_0404;
        issue(mk(4'd2, 5'd7, 5'd7, 5'd2), 1'b0);
        check("sub_read", 64'({rs1_rd_en, rd_wr_en, rs1}), 64'({2'b10, 5'd7}));
        step(); step();
        check("sub_wb", 64'({rd_wr_en, rd, rs1_rd_en}), 64'({1'b1, 5'd7, 1'b0}));
        check("sub_data", wr_data, 64'h0707_0606_0505_0404);
        step();

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
            instr = {op, 28'($urandom)};
            instr_valid = ($urandom_range(0, 3) != 0);
            alu_result = {$urandom, $urandom};
            if ($urandom_range(0, 79) == 0) begin
                #2;
                rst_n = 1'b0;
                m_have = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        instr_valid = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
